// File: rtl/debug_unit_cmd.sv
// ---------------------------------------------------------------------------
// debug_unit_cmd
//
// Command-driven debug controller sitting between the UART word interface
// and the pipelined MIPS core. It first loads the program into instruction
// memory, then obeys host commands (free run, run N cycles, PC breakpoint,
// dump only). After every run it streams back a status word, the PC, a
// data-memory window, the register bank and the core cycle count, one word
// per tx_start/tx_done handshake.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   rx_Data, rx_done           received UART word and its one-cycle strobe
//   tx_done                    previous transmitted word has left the UART
//   halt_flag                  core has retired HALT (level)
//   current_PC, clock_count    core PC and core cycle counter
//   RB_Data, DM_Data           debug read data, one cycle after the address
//   IM_Addr, IM_Data, IM_WrEn  instruction memory write port
//   RB_Addr, DM_Addr           debug read addresses
//   tx_Data, tx_start          word to transmit and its one-cycle start pulse
//   clock_enable               core clock enable (combinational stop gate)
//   o_rst                      core reset, held while a program is loading
// ---------------------------------------------------------------------------
module debug_unit_cmd #(
  parameter int               NBITS          = 32,
  parameter int               IM_ADDR_LENGTH = 32,
  parameter int               IM_DEPTH       = 256,
  parameter int               DM_ADDR_LENGTH = 32,
  parameter int               DM_DUMP_WORDS  = 32,
  parameter int               RBITS          = 5,
  parameter int               BANK_SIZE      = 32,
  parameter logic [NBITS-1:0] END_MARKER     = 32'hFFFFFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NBITS-1:0]          rx_Data,
  input  logic                      rx_done,
  input  logic                      tx_done,
  input  logic                      halt_flag,
  input  logic [NBITS-1:0]          current_PC,
  input  logic [NBITS-1:0]          clock_count,
  input  logic [NBITS-1:0]          RB_Data,
  input  logic [NBITS-1:0]          DM_Data,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [NBITS-1:0]          IM_Data,
  output logic                      IM_WrEn,
  output logic [RBITS-1:0]          RB_Addr,
  output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
  output logic [NBITS-1:0]          tx_Data,
  output logic                      tx_start,
  output logic                      clock_enable,
  output logic                      o_rst
);

  localparam int CBITS = NBITS - 8;

  localparam logic [7:0] OP_RUN    = 8'h01;
  localparam logic [7:0] OP_STEP   = 8'h02;
  localparam logic [7:0] OP_BREAK  = 8'h03;
  localparam logic [7:0] OP_DUMP   = 8'h04;
  localparam logic [7:0] OP_RELOAD = 8'h05;

  localparam logic [IM_ADDR_LENGTH-1:0] IM_LIMIT = IM_ADDR_LENGTH'(IM_DEPTH);
  localparam logic [DM_ADDR_LENGTH-1:0] DM_LAST  = DM_ADDR_LENGTH'(DM_DUMP_WORDS - 1);
  localparam logic [RBITS-1:0]          RB_LAST  = RBITS'(BANK_SIZE - 1);
  localparam logic [CBITS-1:0]          CNT_ONE  = CBITS'(1);

  typedef enum logic [3:0] {
    S_LOAD, S_IDLE, S_GETBP, S_RUN, S_STEP, S_DUMP,
    S_SEND_ST, S_SEND_PC, S_SEND_DM, S_SEND_RB, S_SEND_CLK
  } state_t;

  state_t                    state_q;
  logic [IM_ADDR_LENGTH-1:0] imIndex_q;
  logic [IM_ADDR_LENGTH-1:0] imAddr_q;
  logic [NBITS-1:0]          imData_q;
  logic                      imWrEn_q;
  logic                      oRst_q;
  logic [NBITS-1:0]          txData_q;
  logic                      txStart_q;
  logic [RBITS-1:0]          rbAddr_q;
  logic [DM_ADDR_LENGTH-1:0] dmAddr_q;
  logic [NBITS-1:0]          bpAddr_q;
  logic                      bpValid_q;
  logic                      halted_q;
  logic                      err_q;
  logic                      bpHit_q;
  logic [CBITS-1:0]          stepCnt_q;
  logic                      firstCycle_q;
  logic                      txWait_q;
  logic                      primed_q;
  logic                      shortDump_q;

  logic                      runActive_d;
  logic                      bpMatch_d;
  logic                      stop_d;
  logic [CBITS-1:0]          cmdCount_d;
  logic [NBITS-1:0]          statusWord_d;

  // The breakpoint is ignored in the first cycle of every run so that a run
  // started while sitting on the breakpoint PC actually moves past it.
  always_comb begin
    runActive_d  = (state_q == S_RUN) || (state_q == S_STEP);
    bpMatch_d    = runActive_d && bpValid_q && !firstCycle_q && (current_PC == bpAddr_q);
    stop_d       = halt_flag || bpMatch_d;
    cmdCount_d   = (rx_Data[NBITS-1:8] == '0) ? CNT_ONE : rx_Data[NBITS-1:8];
    statusWord_d = {{(NBITS-3){1'b0}}, err_q, bpHit_q, halted_q};
  end

  // The core is gated in the very cycle a stop condition shows up, so it
  // never advances past a halt or a breakpoint.
  assign clock_enable = runActive_d & ~halt_flag & ~bpMatch_d;

  assign IM_Addr  = imAddr_q;
  assign IM_Data  = imData_q;
  assign IM_WrEn  = imWrEn_q;
  assign RB_Addr  = rbAddr_q;
  assign DM_Addr  = dmAddr_q;
  assign tx_Data  = txData_q;
  assign tx_start = txStart_q;
  assign o_rst    = oRst_q;

  // Main controller. Send states share one pattern: with txWait_q clear a
  // word is launched, then the state waits for tx_done before moving on.
  // DM/RB words need an extra settle cycle (primed_q) so the memory read
  // data matches the address just driven.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      imIndex_q    <= '0;
      imAddr_q     <= '0;
      imData_q     <= '0;
      imWrEn_q     <= 1'b0;
      oRst_q       <= 1'b1;
      txData_q     <= '0;
      txStart_q    <= 1'b0;
      rbAddr_q     <= '0;
      dmAddr_q     <= '0;
      bpAddr_q     <= '0;
      bpValid_q    <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      bpHit_q      <= 1'b0;
      stepCnt_q    <= '0;
      firstCycle_q <= 1'b0;
      txWait_q     <= 1'b0;
      primed_q     <= 1'b0;
      shortDump_q  <= 1'b0;
    end else begin
      imWrEn_q  <= 1'b0;
      txStart_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          oRst_q <= 1'b1;
          if (rx_done) begin
            if (rx_Data == END_MARKER) begin
              imIndex_q <= '0;
              halted_q  <= 1'b0;
              bpValid_q <= 1'b0;
              err_q     <= 1'b0;
              bpHit_q   <= 1'b0;
              oRst_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else if (imIndex_q < IM_LIMIT) begin
              imWrEn_q  <= 1'b1;
              imAddr_q  <= imIndex_q;
              imData_q  <= rx_Data;
              imIndex_q <= imIndex_q + 1'b1;
            end
          end
        end

        S_IDLE: begin
          if (rx_done) begin
            shortDump_q <= 1'b0;
            case (rx_Data[7:0])
              OP_RUN, OP_STEP: begin
                if (halted_q) begin
                  err_q       <= 1'b1;
                  shortDump_q <= 1'b1;
                  state_q     <= S_SEND_ST;
                end else begin
                  firstCycle_q <= 1'b1;
                  stepCnt_q    <= cmdCount_d;
                  state_q      <= (rx_Data[7:0] == OP_RUN) ? S_RUN : S_STEP;
                end
              end
              OP_BREAK:  state_q <= S_GETBP;
              OP_DUMP:   state_q <= S_SEND_ST;
              OP_RELOAD: begin
                oRst_q    <= 1'b1;
                imIndex_q <= '0;
                state_q   <= S_LOAD;
              end
              default: begin
                err_q       <= 1'b1;
                shortDump_q <= 1'b1;
                state_q     <= S_SEND_ST;
              end
            endcase
          end
        end

        S_GETBP: begin
          if (rx_done) begin
            bpAddr_q  <= rx_Data;
            bpValid_q <= (rx_Data != '1);
            state_q   <= S_IDLE;
          end
        end

        S_RUN, S_STEP: begin
          firstCycle_q <= 1'b0;
          if (stop_d) begin
            halted_q <= halt_flag;
            bpHit_q  <= bpMatch_d;
            state_q  <= S_SEND_ST;
          end else if (state_q == S_STEP) begin
            stepCnt_q <= stepCnt_q - 1'b1;
            if (stepCnt_q == CNT_ONE) begin
              state_q <= S_SEND_ST;
            end
          end
        end

        S_SEND_ST: begin
          if (!txWait_q) begin
            txData_q  <= statusWord_d;
            txStart_q <= 1'b1;
            txWait_q  <= 1'b1;
          end else if (tx_done) begin
            txWait_q <= 1'b0;
            if (shortDump_q) begin
              err_q   <= 1'b0;
              bpHit_q <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_SEND_PC;
            end
          end
        end

        S_SEND_PC: begin
          if (!txWait_q) begin
            txData_q  <= current_PC;
            txStart_q <= 1'b1;
            txWait_q  <= 1'b1;
          end else if (tx_done) begin
            txWait_q <= 1'b0;
            dmAddr_q <= '0;
            primed_q <= 1'b0;
            state_q  <= S_SEND_DM;
          end
        end

        S_SEND_DM: begin
          if (txWait_q) begin
            if (tx_done) begin
              txWait_q <= 1'b0;
              primed_q <= 1'b0;
              if (dmAddr_q == DM_LAST) begin
                rbAddr_q <= '0;
                state_q  <= S_SEND_RB;
              end else begin
                dmAddr_q <= dmAddr_q + 1'b1;
              end
            end
          end else if (!primed_q) begin
            primed_q <= 1'b1;
          end else begin
            txData_q  <= DM_Data;
            txStart_q <= 1'b1;
            txWait_q  <= 1'b1;
          end
        end

        S_SEND_RB: begin
          if (txWait_q) begin
            if (tx_done) begin
              txWait_q <= 1'b0;
              primed_q <= 1'b0;
              if (rbAddr_q == RB_LAST) begin
                state_q <= S_SEND_CLK;
              end else begin
                rbAddr_q <= rbAddr_q + 1'b1;
              end
            end
          end else if (!primed_q) begin
            primed_q <= 1'b1;
          end else begin
            txData_q  <= RB_Data;
            txStart_q <= 1'b1;
            txWait_q  <= 1'b1;
          end
        end

        S_SEND_CLK: begin
          if (!txWait_q) begin
            txData_q  <= clock_count;
            txStart_q <= 1'b1;
            txWait_q  <= 1'b1;
          end else if (tx_done) begin
            txWait_q <= 1'b0;
            err_q    <= 1'b0;
            bpHit_q  <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        default: begin
          oRst_q  <= 1'b1;
          state_q <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: doc/debug_unit_cmd.md
# debug_unit_cmd

Command-driven debug controller between the UART word interface (rx/tx of NBITS words) and the pipelined MIPS core. Loads the program into instruction memory, then executes host commands: free run, run N cycles, breakpoint on PC, or dump only. After each run it streams a status word, PC, a DM window, the register bank and the cycle count back to the host. It generalises the earlier single-step/continuous controller with multi-cycle stepping, a PC breakpoint, parametrised dump sizes and an explicit one-word-per-tx handshake.

## Interface
- NBITS, 32, UART word width; also data/instruction width
- IM_ADDR_LENGTH, 32, IM word-address width
- IM_DEPTH, 256, IM words; load words beyond this are dropped
- DM_ADDR_LENGTH, 32, DM word-address width
- DM_DUMP_WORDS, 32, DM words dumped (addresses 0..DM_DUMP_WORDS-1)
- RBITS, 5, register-bank address width
- BANK_SIZE, 32, registers dumped (0..BANK_SIZE-1)
- END_MARKER, 32'hFFFFFFFF, word terminating program load
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_Data  in  NBITS  received word, valid when rx_done
- rx_done  in  1  one-cycle pulse per received word
- tx_done  in  1  one-cycle pulse: previous tx word fully sent
- halt_flag  in  1  core has retired HALT (level)
- current_PC  in  NBITS  core PC
- clock_count  in  NBITS  core cycle counter
- RB_Data  in  NBITS  register read data, 1-cycle latency after RB_Addr
- DM_Data  in  NBITS  data-memory read data, 1-cycle latency after DM_Addr
- IM_Addr  out  IM_ADDR_LENGTH  IM write address
- IM_Data  out  NBITS  IM write data
- IM_WrEn  out  1  IM write strobe, one cycle per word
- RB_Addr  out  RBITS  register debug read address
- DM_Addr  out  DM_ADDR_LENGTH  DM debug read address
- tx_Data  out  NBITS  word to transmit, stable from tx_start until tx_done
- tx_start  out  1  one-cycle pulse per word
- clock_enable  out  1  core clock enable
- o_rst  out  1  core reset

## Operation
- States: LOAD, IDLE, GETBP, RUN, STEP, DUMP, SEND_ST, SEND_PC, SEND_DM, SEND_RB, SEND_CLK.
- LOAD: o_rst=1. Each rx_done with word != END_MARKER and index < IM_DEPTH: IM_WrEn pulse, IM_Addr=index, IM_Data=word, index+1. Words at index ≥ IM_DEPTH ignored. END_MARKER (not written): index←0, halted←0, bp_valid←0, o_rst←0, → IDLE.
- IDLE: on rx_done decode rx_Data[7:0]; n=rx_Data[31:8]:
  - 0x01 RUN → RUN; 0x02 STEP → STEP, step counter ← (n==0 ? 1 : n); 0x03 BREAK → GETBP; 0x04 DUMP → SEND_ST; 0x05 RELOAD → LOAD (o_rst=1 next cycle).
  - Other opcode, or RUN/STEP while halted: err←1, → SEND_ST, short dump (status word only).
- GETBP: next rx word → bp_addr, bp_valid←1 (value 0xFFFFFFFF clears bp_valid), → IDLE; nothing transmitted.
- RUN: clock_enable high until stop. STEP: high until counter reaches 0 (decrement per enabled cycle) or stop.
- Stop condition: halt_flag, or bp_valid && current_PC==bp_addr. Breakpoint compare masked on first cycle of each RUN/STEP so resuming from a breakpoint advances.
- clock_enable = run_active & ~halt_flag & ~bp_match (combinational gate), so the core never advances in the cycle the stop is seen. On stop: halted←halt_flag, bp_hit←bp_match, → SEND_ST.
- Status word = {29'b0, err, bp_hit, halted}; err/bp_hit cleared after SEND_CLK (or after short dump).
- Full dump order: status, PC, DM[0..DM_DUMP_WORDS-1], RB[0..BANK_SIZE-1], clock_count; total 3+DM_DUMP_WORDS+BANK_SIZE words. Then → IDLE (halted stays set).
- rx_done outside LOAD/IDLE/GETBP ignored.

## Timing
- Reset values: state LOAD, o_rst=1, IM_WrEn=0, tx_start=0, clock_enable=0, IM_Addr=IM_Data=RB_Addr=DM_Addr=tx_Data=0, bp_valid=0, halted=0.
- IM write: IM_WrEn in cycle after rx_done.
- Command accepted on rx_done → clock_enable high the next cycle.
- DM/RB word: address driven at cycle t, data captured into tx_Data at t+1, tx_start pulsed at t+1; next address driven in cycle after tx_done.
- Never a second tx_start before tx_done; tx_done in other states ignored.
- STEP n: exactly n cycles with clock_enable=1 if no stop.
- Synchronous reset mid-run/dump: aborts immediately, all outputs to reset values, back to LOAD (program must be reloaded).

## Test plan
- Load 0x20080005, 0x20090003, END_MARKER -> IM_WrEn twice at addresses 0,1 with those data, o_rst falls after marker, no third write.
- STEP cmd 0x00000302 -> clock_enable high exactly 3 cycles, then 3+DM_DUMP_WORDS+BANK_SIZE tx words, status 0x0.
- BREAK 0x03, bp=0x8; RUN -> clock_enable drops the cycle current_PC==8, status 0x2, PC word 0x8; second RUN advances past 8.
- RUN with halt_flag at cycle 10 -> status 0x1, clock_count word sent last; subsequent RUN -> single status word 0x5.
- Opcode 0x7F -> single tx word 0x4, return to IDLE, clock_enable never high.
- reset asserted during SEND_DM with tx_start pending -> next cycle tx_start=0, o_rst=1, state LOAD; fresh load works.
